// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//
// This is the last stage of the RISC-V pipeline. It holds the result bundle
// taken from the M stage. It then picks the final value: the ALU result, the
// extracted load data, or PC+4. It drives the register-file write port.
//
// A load is held in LOAD_WAIT until the data-memory response arrives. Memory
// latency can therefore vary. While the stage waits, it stalls the upstream
// stages. Every retired instruction is counted in o_instret.
//
// Ports:
//   clk, rst_n                  clock; synchronous active-low reset
//   i_valid_M                   M bundle is a real instruction (0 = bubble)
//   i_ALU_output_M              ALU result; byte address for loads
//   i_pc_plus4_M                link value for JAL/JALR
//   i_register_file_wr_addr_M   destination register
//   i_register_file_wr_en_M     instruction writes a register
//   i_sel_result_M              00 ALU, 01 load, 10 PC+4, 11 ALU
//   i_load_funct3_M             RISC-V load funct3
//   i_mem_rsp_valid/data        data-memory response (raw aligned word)
//   o_result_W                  register-file write data
//   o_register_file_wr_en_W     register-file write strobe
//   o_register_file_wr_addr_W   register-file write address
//   o_stall_W                   upstream must hold its bundle this cycle
//   o_retire_W                  an instruction retires this cycle
//   o_instret                   retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module writeback_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid_M,
    input  logic [XLEN-1:0]       i_ALU_output_M,
    input  logic [XLEN-1:0]       i_pc_plus4_M,
    input  logic [REG_ADDR_W-1:0] i_register_file_wr_addr_M,
    input  logic                  i_register_file_wr_en_M,
    input  logic [1:0]            i_sel_result_M,
    input  logic [2:0]            i_load_funct3_M,
    input  logic                  i_mem_rsp_valid,
    input  logic [XLEN-1:0]       i_mem_rsp_data,
    output logic [XLEN-1:0]       o_result_W,
    output logic                  o_register_file_wr_en_W,
    output logic [REG_ADDR_W-1:0] o_register_file_wr_addr_W,
    output logic                  o_stall_W,
    output logic                  o_retire_W,
    output logic [CNT_W-1:0]      o_instret
);

    localparam int   LANE_W = (XLEN == 64) ? 3 : 2;
    localparam logic IS64   = (XLEN == 64);

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        RESULT    = 2'd1,
        LOAD_WAIT = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [XLEN-1:0]         alu_reg;
    logic [XLEN-1:0]         pc4_reg;
    logic [REG_ADDR_W-1:0]   addr_reg;
    logic                    wen_reg;
    logic [1:0]              sel_reg;
    logic [2:0]              funct3_reg;
    logic [CNT_W-1:0]        instret_reg;

    logic                    stall;
    logic                    retire;
    logic [LANE_W-1:0]       lane;
    logic [7:0]              byte_val;
    logic [15:0]             half_val;
    logic [31:0]             word_val;
    logic [XLEN-1:0]         load_data;
    logic [XLEN-1:0]         result;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        retire     = 1'b0;
        case (state_reg)
            RESULT:    retire = 1'b1;
            LOAD_WAIT: begin
                // Only a response seen while waiting counts; stray ones are ignored.
                if (i_mem_rsp_valid) retire = 1'b1;
                else                 stall  = 1'b1;
            end
            default:   ;
        endcase
        // A free stage captures the next bundle on the same edge that the
        // current instruction retires.
        if (!stall) begin
            if (!i_valid_M)                 state_next = EMPTY;
            else if (i_sel_result_M == 2'b01) state_next = LOAD_WAIT;
            else                            state_next = RESULT;
        end
    end

    // ------------------------------------------------------ bundle capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_reg    <= '0;
            pc4_reg    <= '0;
            addr_reg   <= '0;
            wen_reg    <= 1'b0;
            sel_reg    <= 2'b00;
            funct3_reg <= 3'b000;
        end else if (!stall) begin
            alu_reg    <= i_ALU_output_M;
            pc4_reg    <= i_pc_plus4_M;
            addr_reg   <= i_register_file_wr_addr_M;
            wen_reg    <= i_register_file_wr_en_M;
            sel_reg    <= i_sel_result_M;
            funct3_reg <= i_load_funct3_M;
        end
    end

    // ------------------------------------------------------ load extraction
    // Lane bits are used exactly as given. A misaligned half-word or word
    // simply selects the enclosing aligned lane.
    always_comb begin
        lane     = alu_reg[LANE_W-1:0];
        byte_val = 8'(i_mem_rsp_data >> {lane, 3'b000});
        half_val = 16'(i_mem_rsp_data >> {lane[LANE_W-1:1], 4'b0000});
        word_val = 32'(i_mem_rsp_data >> {(IS64 & alu_reg[2]), 5'b00000});
        case (funct3_reg)
            3'b000:  load_data = XLEN'($signed(byte_val));
            3'b001:  load_data = XLEN'($signed(half_val));
            3'b100:  load_data = XLEN'(byte_val);
            3'b101:  load_data = XLEN'(half_val);
            3'b010:  load_data = IS64 ? XLEN'($signed(word_val)) : i_mem_rsp_data;
            3'b110:  load_data = IS64 ? XLEN'(word_val) : i_mem_rsp_data;
            default: load_data = i_mem_rsp_data;   // LD and unlisted encodings
        endcase
    end

    always_comb begin
        case (sel_reg)
            2'b01:   result = load_data;
            2'b10:   result = pc4_reg;
            default: result = alu_reg;
        endcase
    end

    // ------------------------------------------------------ retire counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instret_reg <= '0;
        end else if (retire) begin
            instret_reg <= instret_reg + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------- outputs
    assign o_result_W                = result;
    assign o_register_file_wr_addr_W = addr_reg;
    assign o_register_file_wr_en_W   = retire & wen_reg & (addr_reg != '0);
    assign o_stall_W                 = stall;
    assign o_retire_W                = retire;
    assign o_instret                 = instret_reg;

endmodule

// File: tb/tb_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_writeback_stage
//
// Directed testbench for writeback_stage. It uses the default XLEN=32
// instance plus a second instance with CNT_W=4. Both instances share the
// same stimulus. The second instance is used to observe counter wrap.
// Inputs are driven 2 time units after each rising edge. Outputs are
// sampled 1 time unit later, well away from the clock edge.
// -----------------------------------------------------------------------------
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [4:0]  wa;
    logic        we;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    logic [31:0] result;
    logic        wr_en_w;
    logic [4:0]  wr_addr_w;
    logic        stall;
    logic        retire;
    logic [63:0] instret;

    logic [31:0] result4;
    logic        wr_en_w4;
    logic [4:0]  wr_addr_w4;
    logic        stall4;
    logic        retire4;
    logic [3:0]  instret4;

    int n_vec = 0;
    int n_err = 0;
    longint exp_cnt = 0;

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .i_valid_M                 (valid),
        .i_ALU_output_M            (alu),
        .i_pc_plus4_M              (pc4),
        .i_register_file_wr_addr_M (wa),
        .i_register_file_wr_en_M   (we),
        .i_sel_result_M            (sel),
        .i_load_funct3_M           (f3),
        .i_mem_rsp_valid           (rsp_valid),
        .i_mem_rsp_data            (rsp_data),
        .o_result_W                (result),
        .o_register_file_wr_en_W   (wr_en_w),
        .o_register_file_wr_addr_W (wr_addr_w),
        .o_stall_W                 (stall),
        .o_retire_W                (retire),
        .o_instret                 (instret)
    );

    writeback_stage #(.CNT_W(4)) dut4 (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .i_valid_M                 (valid),
        .i_ALU_output_M            (alu),
        .i_pc_plus4_M              (pc4),
        .i_register_file_wr_addr_M (wa),
        .i_register_file_wr_en_M   (we),
        .i_sel_result_M            (sel),
        .i_load_funct3_M           (f3),
        .i_mem_rsp_valid           (rsp_valid),
        .i_mem_rsp_data            (rsp_data),
        .o_result_W                (result4),
        .o_register_file_wr_en_W   (wr_en_w4),
        .o_register_file_wr_addr_W (wr_addr_w4),
        .o_stall_W                 (stall4),
        .o_retire_W                (retire4),
        .o_instret                 (instret4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compares the per-cycle control outputs. It compares address and data
    // only on cycles that retire.
    task automatic chk_out(input string tag, input logic e_ret, input logic e_we,
                           input logic e_stall, input logic [4:0] e_addr,
                           input logic [31:0] e_res);
        chk({tag, ".retire"}, 64'(retire), 64'(e_ret));
        chk({tag, ".wr_en"},  64'(wr_en_w), 64'(e_we));
        chk({tag, ".stall"},  64'(stall), 64'(e_stall));
        if (e_ret) begin
            chk({tag, ".addr"},   64'(wr_addr_w), 64'(e_addr));
            chk({tag, ".result"}, 64'(result), 64'(e_res));
        end
        $display("step %-14s ret=%0b we=%0b stall=%0b addr=%0d res=%08h instret=%0d",
                 tag, retire, wr_en_w, stall, wr_addr_w, result, instret);
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] p,
                         input logic [4:0] d, input logic w, input logic [1:0] s,
                         input logic [2:0] f);
        valid = v; alu = a; pc4 = p; wa = d; we = w; sel = s; f3 = f;
    endtask

    task automatic bubble;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 3'b000);
    endtask

    // Applies a load with an immediate response, then checks the extracted value.
    task automatic load_case(input string tag, input logic [31:0] addr,
                             input logic [2:0] fn, input logic [31:0] exp_res);
        drive(1'b1, addr, 32'h0, 5'd7, 1'b1, 2'b01, fn);
        tick;
        bubble;
        rsp_valid = 1'b1;
        rsp_data  = 32'h80FF_7F01;
        #1;
        chk_out(tag, 1'b1, 1'b1, 1'b0, 5'd7, exp_res);
        tick;
        exp_cnt++;
        rsp_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        rsp_valid = 1'b0;
        rsp_data = 32'h0;
        bubble;
        tick;
        tick;
        rst_n = 1'b1;
        #1;
        chk_out("reset", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("reset.result", 64'(result), 64'h0);
        chk("reset.addr", 64'(wr_addr_w), 64'h0);
        chk("reset.instret", instret, 64'd0);

        // ALU result to x5
        drive(1'b1, 32'h1234_5678, 32'h0, 5'd5, 1'b1, 2'b00, 3'b000);
        tick;
        bubble;
        #1;
        chk_out("alu", 1'b1, 1'b1, 1'b0, 5'd5, 32'h1234_5678);
        chk("alu.instret_before", instret, 64'(exp_cnt));
        tick;
        exp_cnt++;
        #1;
        chk("alu.instret_after", instret, 64'(exp_cnt));

        // A write to x0 still retires and counts
        drive(1'b1, 32'hAAAA_0000, 32'h0, 5'd0, 1'b1, 2'b00, 3'b000);
        tick;
        bubble;
        #1;
        chk_out("x0", 1'b1, 1'b0, 1'b0, 5'd0, 32'hAAAA_0000);
        tick;
        exp_cnt++;
        #1;
        chk_out("bubble", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("bubble.instret", instret, 64'(exp_cnt));
        tick;
        #1;
        chk("bubble.instret2", instret, 64'(exp_cnt));

        // Load extraction from 0x80FF_7F01
        load_case("lb@3",  32'h1003, 3'b000, 32'hFFFF_FF80);
        load_case("lbu@3", 32'h1003, 3'b100, 32'h0000_0080);
        load_case("lh@2",  32'h1002, 3'b001, 32'hFFFF_80FF);
        load_case("lhu@0", 32'h1000, 3'b101, 32'h0000_7F01);
        load_case("lb@0",  32'h1000, 3'b000, 32'h0000_0001);
        load_case("lw@0",  32'h1000, 3'b010, 32'h80FF_7F01);
        load_case("f3=011", 32'h1001, 3'b011, 32'h80FF_7F01);
        #1;
        chk("loads.instret", instret, 64'(exp_cnt));

        // Delayed load: the response is held off for 3 cycles
        drive(1'b1, 32'h2000, 32'h0, 5'd9, 1'b1, 2'b01, 3'b010);
        tick;
        drive(1'b1, 32'h0000_CAFE, 32'h0, 5'd10, 1'b1, 2'b00, 3'b000);
        rsp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk_out($sformatf("wait%0d", k), 1'b0, 1'b0, 1'b1, 5'd0, 32'h0);
            tick;
        end
        #1;
        chk("wait.instret", instret, 64'(exp_cnt));
        rsp_valid = 1'b1;
        rsp_data  = 32'hDEAD_BEEF;
        #1;
        chk_out("ld_retire", 1'b1, 1'b1, 1'b0, 5'd9, 32'hDEAD_BEEF);
        tick;
        exp_cnt++;
        bubble;
        // This response arrives outside LOAD_WAIT, so it must be ignored.
        rsp_data = 32'h1111_1111;
        #1;
        chk_out("held_alu", 1'b1, 1'b1, 1'b0, 5'd10, 32'h0000_CAFE);
        tick;
        exp_cnt++;
        rsp_valid = 1'b0;

        // JAL writes PC+4 to x1; sel=11 behaves like ALU
        drive(1'b1, 32'h0000_0999, 32'h0000_0104, 5'd1, 1'b1, 2'b10, 3'b000);
        tick;
        drive(1'b1, 32'h0000_0055, 32'h0000_0777, 5'd3, 1'b1, 2'b11, 3'b000);
        #1;
        chk_out("jal", 1'b1, 1'b1, 1'b0, 5'd1, 32'h0000_0104);
        tick;
        exp_cnt++;
        drive(1'b1, 32'h0000_0066, 32'h0, 5'd4, 1'b0, 2'b00, 3'b000);
        #1;
        chk_out("sel11", 1'b1, 1'b1, 1'b0, 5'd3, 32'h0000_0055);
        tick;
        exp_cnt++;
        bubble;
        #1;
        chk_out("no_wr_en", 1'b1, 1'b0, 1'b0, 5'd4, 32'h0000_0066);
        tick;
        exp_cnt++;
        #1;
        chk("pre_rst.instret", instret, 64'(exp_cnt));

        // Reset while a load is pending, followed by a stray response
        drive(1'b1, 32'h3000, 32'h0, 5'd12, 1'b1, 2'b01, 3'b010);
        tick;
        bubble;
        #1;
        chk("ldrst.stall", 64'(stall), 64'd1);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        rsp_valid = 1'b1;
        rsp_data = 32'h5555_5555;
        exp_cnt = 0;
        #1;
        chk_out("after_rst", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("after_rst.result", 64'(result), 64'h0);
        chk("after_rst.instret", instret, 64'd0);
        tick;
        rsp_valid = 1'b0;
        #1;
        chk_out("stray_rsp", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("stray_rsp.instret", instret, 64'd0);
        chk("stray_rsp.instret4", 64'(instret4), 64'd0);

        // 16 back-to-back retires wrap the 4-bit counter to 0
        drive(1'b1, 32'h0000_00AB, 32'h0, 5'd2, 1'b1, 2'b00, 3'b000);
        for (int i = 0; i < 16; i++) tick;
        bubble;
        #1;
        chk("wrap.instret4_15", 64'(instret4), 64'd15);
        chk_out("wrap_last", 1'b1, 1'b1, 1'b0, 5'd2, 32'h0000_00AB);
        tick;
        #1;
        chk("wrap.instret4", 64'(instret4), 64'd0);
        chk("wrap.instret64", instret, 64'd16);
        chk("wrap.retire4", 64'(retire4), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Parametrised writeback stage for the RISC-V pipeline: registers the M-stage result bundle, selects the final result from ALU output, load data or PC+4, and drives the register-file write port. Loads retire only when the data-memory response arrives, so memory latency can vary. While a load waits, the stage stalls upstream, and it counts retired instructions. Sits between the memory stage and the register file / forwarding network.

## Interface

- XLEN, 32: datapath width; 32 or 64 only.
- REG_ADDR_W, 5: register-file address width.
- CNT_W, 64: retire-counter width.

- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- i_valid_M  in  1  M-stage bundle holds a real instruction; 0 = bubble.
- i_ALU_output_M  in  XLEN  ALU result; for loads, the byte address.
- i_pc_plus4_M  in  XLEN  link value for JAL/JALR.
- i_register_file_wr_addr_M  in  REG_ADDR_W  destination register.
- i_register_file_wr_en_M  in  1  instruction writes a register.
- i_sel_result_M  in  2  00 ALU, 01 load data, 10 PC+4, 11 treated as 00.
- i_load_funct3_M  in  3  load type, RISC-V funct3 encoding.
- i_mem_rsp_valid  in  1  data-memory response valid this cycle.
- i_mem_rsp_data  in  XLEN  raw aligned memory word.
- o_result_W  out  XLEN  value written to the register file.
- o_register_file_wr_en_W  out  1  register-file write strobe.
- o_register_file_wr_addr_W  out  REG_ADDR_W  register-file write address.
- o_stall_W  out  1  upstream must hold the M bundle this cycle.
- o_retire_W  out  1  one instruction retires this cycle.
- o_instret  out  CNT_W  count of retired instructions.

## Operation

- State: EMPTY (no valid instruction), RESULT (non-load held), LOAD_WAIT (load held, data pending).
- Capture: on each posedge with rst_n=1 and o_stall_W=0, the stage registers the M bundle. The next state is EMPTY if i_valid_M=0, LOAD_WAIT if i_sel_result_M=01, else RESULT.
- Hold: while o_stall_W=1, all stage registers keep their values and the M bundle is ignored.
- o_stall_W = (state==LOAD_WAIT) & ~i_mem_rsp_valid. This is combinational from state and i_mem_rsp_valid.
- Retire: o_retire_W = (state==RESULT) | (state==LOAD_WAIT & i_mem_rsp_valid).
- Write: o_register_file_wr_en_W = o_retire_W & wr_en & (wr_addr != 0). Writes to x0 are always suppressed.
- Result select: ALU output; PC+4; or load data extracted from i_mem_rsp_data.
- Load extraction, XLEN=32, lane = address[1:0]:
  - 000 LB: sign-extend byte [lane*8 +: 8].
  - 001 LH: sign-extend half [address[1]*16 +: 16].
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
- Load extraction, XLEN=64, lane = address[2:0]:
  - Byte and half loads: same encodings as XLEN=32, with the wider lane field.
  - 010 LW: sign-extend word [address[2]*32 +: 32].
  - 110 LWU: zero-extend the same word.
  - 011 LD: full doubleword.
- Unlisted funct3 values pass the raw word through unchanged.
- A misaligned address uses the lane bits as given; no trap is raised.
- i_mem_rsp_valid outside LOAD_WAIT is ignored. Only the response in the retiring cycle is used.
- o_instret increments by 1 on every o_retire_W, including retires with no register write. It wraps modulo 2^CNT_W.

## Timing

- Reset (rst_n=0 at posedge): state=EMPTY, all held registers cleared, o_instret=0. As a result, all outputs are 0 from the first cycle after reset.
- Reset mid-load: a pending load is discarded and not counted. A response arriving after reset is ignored.
- Non-load latency: a bundle captured at edge N drives its result and write in cycle N to N+1 and retires once.
- Load latency: retires in the first cycle, at or after capture, in which i_mem_rsp_valid=1.
  - A response in the capture cycle gives zero stall.
  - Each response-less cycle adds exactly one stall cycle.
- Back-to-back: the cycle a load retires (o_stall_W=0), the next M bundle is captured at that same edge.
- o_result_W is don't-care when o_retire_W=0. The bench checks it only on retiring cycles.

## Test plan

- ALU: valid, sel=00, ALU=0x1234_5678, addr=5, wr_en=1 -> next cycle wr_en_W=1, addr_W=5, result=0x1234_5678, instret 0->1.
- x0 and bubble: addr=0, wr_en=1 -> retire=1, wr_en_W=0, instret incremented. Then i_valid_M=0 -> retire=0, instret unchanged.
- Load sign/zero, XLEN=32, rsp_data=0x80FF_7F01:
  - LB at addr 3 -> 0xFFFF_FF80.
  - LBU at addr 3 -> 0x0000_0080.
  - LH at addr 2 -> 0xFFFF_80FF.
  - LHU at addr 0 -> 0x0000_7F01.
- Delayed load: response held off for 3 cycles -> o_stall_W=1 for exactly 3 cycles, next M bundle held. Retire and write in the 4th cycle, then the held bundle is captured at that edge.
- JAL: sel=10, pc_plus4=0x0000_0104, addr=1 -> result 0x0000_0104, write x1.
- Reset during LOAD_WAIT, then a stray response -> all outputs 0, instret=0, no write. Also: with CNT_W=4, 16 retires wrap instret to 0.
